// File: rtl/fpnew_norm_sticky_if.sv
// Operand/result handshake bundle between the FMA/cast datapath, the iterative
// normalizer and the downstream rounding block.
interface fpnew_norm_sticky_if #(
  parameter int InWidth      = 16,
  parameter int MantWidth    = 8,
  parameter int ExpWidth     = 8,
  parameter int RsrPrecision = 4
);
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [InWidth-1:0]         mant_i;
  logic signed [ExpWidth-1:0] exp_i;
  logic                       sign_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [MantWidth-1:0]       mant_o;
  logic signed [ExpWidth-1:0] exp_o;
  logic                       sign_o;
  logic [1:0]                 round_sticky_o;
  logic [RsrPrecision-1:0]    stochastic_bits_o;
  logic                       zero_o;

  modport master (
    output in_valid_i, mant_i, exp_i, sign_i, out_ready_i,
    input  in_ready_o, out_valid_o, mant_o, exp_o, sign_o,
           round_sticky_o, stochastic_bits_o, zero_o
  );

  modport slave (
    input  in_valid_i, mant_i, exp_i, sign_i, out_ready_i,
    output in_ready_o, out_valid_o, mant_o, exp_o, sign_o,
           round_sticky_o, stochastic_bits_o, zero_o
  );
endinterface

// File: rtl/fpnew_norm_sticky.sv
// Iterative left/right normalizer producing mantissa, round/sticky and exponent for rounding.
// Define FPNEW_NORM_RSR_EN to drive stochastic_bits_o; otherwise it is tied to zero.
module fpnew_norm_sticky #(
  parameter int InWidth      = 16,
  parameter int MantWidth    = 8,
  parameter int ExpWidth     = 8,
  parameter int RsrPrecision = 4,
  parameter int ShiftStep    = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  input logic                flush_i,
  fpnew_norm_sticky_if.slave bus
);

  localparam int LowW = InWidth - MantWidth - 1;

  typedef logic signed [ExpWidth:0] exp_t;
  typedef logic [InWidth-1:0]       mant_t;
  typedef enum logic [1:0] {Idle, Shift, Done} state_e;

  localparam exp_t ExpOne = exp_t'(1);

  function automatic logic norm_done(input mant_t m, input exp_t e);
    return (m == '0) || m[InWidth-1] || (e <= ExpOne);
  endfunction

  function automatic int lead_zeros(input mant_t m);
    int lz = ShiftStep;
    for (int i = ShiftStep - 1; i >= 0; i--) begin
      if (m[InWidth-1-i]) lz = i;
    end
    return lz;
  endfunction

  // OR of every bit strictly below position n; n >= InWidth covers the whole word.
  function automatic logic sticky_below(input mant_t m, input int n);
    return |(m & ~({InWidth{1'b1}} << n));
  endfunction

  state_e state_q;
  logic   out_valid_q;
  mant_t  mant_q;
  exp_t   exp_q;
  logic   sticky_q;
  logic   sign_q;

  logic [MantWidth-1:0]       mant_o_q;
  logic signed [ExpWidth-1:0] exp_o_q;
  logic                       sign_o_q;
  logic [1:0]                 rs_q;
  logic                       zero_q;

  exp_t  exp_ext, d_exp, acc_exp, sh_exp, fin_exp;
  mant_t acc_mant, sh_mant, fin_mant;
  logic  acc_sticky, fin_sticky, fin_sign, fin_done, out_sticky, enter_done;
  int    d_amt, sh_amt, sh_lim;

  always_comb begin
    exp_ext = {bus.exp_i[ExpWidth-1], bus.exp_i};
    d_exp   = ExpOne - exp_ext;
    d_amt   = int'(d_exp);
    if (d_amt > InWidth) d_amt = InWidth;

    // Accept path: denormalize right so the exponent lands on 1.
    if (exp_ext < ExpOne) begin
      acc_mant   = bus.mant_i >> d_amt;
      acc_sticky = sticky_below(bus.mant_i, d_amt);
      acc_exp    = ExpOne;
    end else begin
      acc_mant   = bus.mant_i;
      acc_sticky = 1'b0;
      acc_exp    = exp_ext;
    end

    sh_lim = int'(exp_q) - 1;
    sh_amt = lead_zeros(mant_q);
    if (sh_lim < sh_amt) sh_amt = sh_lim;
    if (sh_amt < 0) sh_amt = 0;
    sh_mant = mant_q << sh_amt;
    sh_exp  = exp_q - exp_t'(sh_amt);

    if (state_q == Idle) begin
      fin_mant   = acc_mant;
      fin_exp    = acc_exp;
      fin_sticky = acc_sticky;
      fin_sign   = bus.sign_i;
    end else begin
      fin_mant   = sh_mant;
      fin_exp    = sh_exp;
      fin_sticky = sticky_q;
      fin_sign   = sign_q;
    end

    fin_done   = norm_done(fin_mant, fin_exp);
    out_sticky = fin_sticky | sticky_below(fin_mant, LowW);
    enter_done = fin_done && (((state_q == Idle) && bus.in_valid_i) || (state_q == Shift));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      out_valid_q <= 1'b0;
      mant_q      <= '0;
      exp_q       <= '0;
      sticky_q    <= 1'b0;
      sign_q      <= 1'b0;
      mant_o_q    <= '0;
      exp_o_q     <= '0;
      sign_o_q    <= 1'b0;
      rs_q        <= '0;
      zero_q      <= 1'b0;
    end else if (flush_i) begin
      state_q     <= Idle;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          if (bus.in_valid_i) begin
            mant_q   <= acc_mant;
            exp_q    <= acc_exp;
            sticky_q <= acc_sticky;
            sign_q   <= bus.sign_i;
            state_q  <= fin_done ? Done : Shift;
          end
        end
        Shift: begin
          mant_q <= sh_mant;
          exp_q  <= sh_exp;
          if (fin_done) state_q <= Done;
        end
        Done: begin
          if (bus.out_ready_i) begin
            state_q     <= Idle;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= Idle;
      endcase

      // Result fields are captured once, on entry to Done, and held there.
      if (enter_done) begin
        out_valid_q <= 1'b1;
        mant_o_q    <= fin_mant[InWidth-1 -: MantWidth];
        exp_o_q     <= fin_mant[InWidth-1] ? fin_exp[ExpWidth-1:0] : '0;
        sign_o_q    <= fin_sign;
        rs_q        <= {fin_mant[LowW], out_sticky};
        zero_q      <= (fin_mant == '0) && !out_sticky;
      end
    end
  end

`ifdef FPNEW_NORM_RSR_EN
  logic [RsrPrecision-1:0] stoch_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stoch_q <= '0;
    end else if (!flush_i && enter_done) begin
      stoch_q <= fin_mant[LowW -: RsrPrecision];
    end
  end

  assign bus.stochastic_bits_o = stoch_q;
`else
  assign bus.stochastic_bits_o = {RsrPrecision{1'b0}};
`endif

  assign bus.in_ready_o     = (state_q == Idle);
  assign bus.out_valid_o    = out_valid_q;
  assign bus.mant_o         = mant_o_q;
  assign bus.exp_o          = exp_o_q;
  assign bus.sign_o         = sign_o_q;
  assign bus.round_sticky_o = rs_q;
  assign bus.zero_o         = zero_q;

endmodule

// File: tb/tb_fpnew_norm_sticky.sv
// Self-checking bench for fpnew_norm_sticky: directed vectors plus randomized
// operands against a bit-at-a-time reference normalizer.
module tb_fpnew_norm_sticky;

  typedef struct packed {
    logic [7:0] mant;
    logic [7:0] expo;
    logic       sign;
    logic [1:0] rs;
    logic [3:0] stoch;
    logic       zero;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fpnew_norm_sticky_if #(.InWidth(16), .MantWidth(8), .ExpWidth(8), .RsrPrecision(4)) bus ();

  fpnew_norm_sticky #(
    .InWidth(16), .MantWidth(8), .ExpWidth(8), .RsrPrecision(4), .ShiftStep(4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (bus)
  );

  logic [15:0] tm [6] = '{16'h8000, 16'h0030, 16'h0100, 16'h8001, 16'h80C1, 16'h0000};
  int          te [6] = '{10, 20, 4, -2, 5, 7};
  logic        ts [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0]  xm [6] = '{8'h80, 8'hC0, 8'h08, 8'h10, 8'h80, 8'h00};
  logic [7:0]  xe [6] = '{8'd10, 8'd10, 8'd0, 8'd0, 8'd5, 8'd0};
  logic [1:0]  xr [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00};
  logic [3:0]  xs [6] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hC, 4'h0};
  logic        xz [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int          xl [6] = '{1, 4, 2, 1, 1, 1};

  function automatic logic [3:0] rsr(input logic [3:0] x);
`ifdef FPNEW_NORM_RSR_EN
    return x;
`else
    return 4'h0 & x;
`endif
  endfunction

  // Reference: denormalize one bit at a time, then normalize one bit at a time.
  function automatic void ref_model(input logic [15:0] m_in, input int e_in, input logic s,
                                    output res_t r, output int lat);
    int unsigned m = m_in;
    int          e = e_in;
    bit          stk = 1'b0;
    bit          stk_all;
    int          k = 0;
    if (e < 1) begin
      for (int i = 0; i < 1 - e; i++) begin
        stk = stk | m[0];
        m   = m >> 1;
      end
      e = 1;
    end
    while (m != 0 && m < 32768 && e > 1) begin
      m = m << 1;
      e = e - 1;
      k = k + 1;
    end
    stk_all = stk || ((m & 32'h7F) != 0);
    r.mant  = 8'(m >> 8);
    r.expo  = (m >= 32768) ? 8'(e) : 8'd0;
    r.sign  = s;
    r.rs    = {m[7], stk_all};
    r.stoch = rsr(4'(m >> 4));
    r.zero  = (m == 0) && !stk_all;
    lat     = 1 + (k + 3) / 4;
  endfunction

  function automatic res_t sample_out();
    res_t r;
    r.mant  = bus.mant_o;
    r.expo  = bus.exp_o;
    r.sign  = bus.sign_o;
    r.rs    = bus.round_sticky_o;
    r.stoch = bus.stochastic_bits_o;
    r.zero  = bus.zero_o;
    return r;
  endfunction

  // Presents one operand, waits for the result and completes the output handshake.
  task automatic run_op(input logic [15:0] m, input logic signed [7:0] e, input logic s,
                        input bit rdy_hi, output res_t obs, output int lat,
                        output bit timeout, output bit idle_after);
    int w = 0;
    timeout = 1'b0;
    obs = '0;
    lat = 0;
    idle_after = 1'b0;
    bus.out_ready_i = rdy_hi;
    while (!bus.in_ready_o && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.in_ready_o) begin
      timeout = 1'b1;
      return;
    end
    bus.in_valid_i = 1'b1;
    bus.mant_i = m;
    bus.exp_i = e;
    bus.sign_i = s;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    bus.mant_i = 16'($urandom);
    bus.exp_i = 8'($urandom);
    bus.sign_i = ~s;
    lat = 1;
    while (!bus.out_valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid_o) begin
      timeout = 1'b1;
      return;
    end
    obs = sample_out();
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    idle_after = bus.in_ready_o && !bus.out_valid_o;
    bus.out_ready_i = rdy_hi;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({bus.in_ready_o, bus.out_valid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready/valid %b required 10", {bus.in_ready_o, bus.out_valid_o});
    end
    n_checks++;
    if (sample_out() !== res_t'(0)) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", sample_out());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    res_t obs, expv;
    int lat;
    bit to, idle;
    for (int i = 0; i < 6; i++) begin
      run_op(tm[i], 8'(te[i]), ts[i], 1'b0, obs, lat, to, idle);
      expv = {xm[i], xe[i], ts[i], xr[i], rsr(xs[i]), xz[i]};
      n_checks++;
      if (to || obs !== expv) begin
        n_fail++;
        $display("FAIL directed_%0d: got %h (timeout %0d) required %h", i, obs, to, expv);
      end
      n_checks++;
      if (lat !== xl[i]) begin
        n_fail++;
        $display("FAIL directed_lat_%0d: got %0d required %0d", i, lat, xl[i]);
      end
    end
  endtask

  task automatic test_random(input int n, input bit rdy_hi, input string tag);
    res_t obs, expv;
    int lat, xlat;
    bit to, idle;
    logic [15:0] m;
    logic signed [7:0] e;
    for (int i = 0; i < n; i++) begin
      m = 16'($urandom) >> $urandom_range(0, 16);
      if ($urandom_range(0, 3) == 0) e = 8'($urandom);
      else e = 8'(int'($urandom_range(0, 40)) - 10);
      ref_model(m, int'(e), 1'($urandom), expv, xlat);
      run_op(m, e, expv.sign, rdy_hi, obs, lat, to, idle);
      n_checks++;
      if (to || obs !== expv) begin
        n_fail++;
        $display("FAIL %s_data m=%h e=%0d: got %h required %h", tag, m, e, obs, expv);
      end
      n_checks++;
      if (lat !== xlat) begin
        n_fail++;
        $display("FAIL %s_lat m=%h e=%0d: got %0d required %0d", tag, m, e, lat, xlat);
      end
      n_checks++;
      if (idle !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_idle_after: got %0d required 1", tag, idle);
      end
    end
  endtask

  task automatic test_back_to_back();
    test_random(40, 1'b1, "b2b");
  endtask

  task automatic test_backpressure();
    res_t expv;
    int xlat, w = 0;
    bit bad = 1'b0;
    ref_model(16'h0030, 20, 1'b1, expv, xlat);
    bus.out_ready_i = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.mant_i = 16'h0030;
    bus.exp_i = 8'sd20;
    bus.sign_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    while (!bus.out_valid_o && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    for (int c = 0; c < 5; c++) begin
      if (!bus.out_valid_o || bus.in_ready_o || sample_out() !== expv) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL backpressure_hold: got %h valid %0d required %h valid 1", sample_out(), bus.out_valid_o, expv);
    end
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    n_checks++;
    if ({bus.in_ready_o, bus.out_valid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL backpressure_release: got %b required 10", {bus.in_ready_o, bus.out_valid_o});
    end
  endtask

  task automatic test_flush();
    bit bad = 1'b0;
    res_t obs, expv;
    int lat, xlat;
    bit to, idle;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.mant_i = 16'h0030;
    bus.exp_i = 8'sd20;
    bus.sign_i = 1'b0;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if ({bus.in_ready_o, bus.out_valid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_shift: got %b required 10", {bus.in_ready_o, bus.out_valid_o});
    end
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid_o) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL flush_no_valid: got valid 1 required 0");
    end
    bus.in_valid_i = 1'b1;
    bus.mant_i = 16'h8000;
    bus.exp_i = 8'sd3;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    n_checks++;
    if ({bus.in_ready_o, bus.out_valid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_vs_accept: got %b required 10", {bus.in_ready_o, bus.out_valid_o});
    end
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if ({bus.in_ready_o, bus.out_valid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_done: got %b required 10", {bus.in_ready_o, bus.out_valid_o});
    end
    ref_model(16'h0123, 9, 1'b1, expv, xlat);
    run_op(16'h0123, 8'sd9, 1'b1, 1'b0, obs, lat, to, idle);
    n_checks++;
    if (to || obs !== expv || lat !== xlat) begin
      n_fail++;
      $display("FAIL flush_recover: got %h lat %0d required %h lat %0d", obs, lat, expv, xlat);
    end
  endtask

  task automatic test_reset_mid();
    res_t obs, expv;
    int lat, xlat;
    bit to, idle;
    run_op(16'hFFFF, 8'sd3, 1'b1, 1'b0, obs, lat, to, idle);
    bus.in_valid_i = 1'b1;
    bus.mant_i = 16'h0001;
    bus.exp_i = 8'sd60;
    bus.sign_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready_o, bus.out_valid_o, sample_out()} !== {2'b10, res_t'(0)}) begin
      n_fail++;
      $display("FAIL reset_mid: got %b/%h required 10/000000", {bus.in_ready_o, bus.out_valid_o}, sample_out());
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_dropped: got valid %0d required 0", bus.out_valid_o);
    end
    ref_model(16'h0001, 60, 1'b0, expv, xlat);
    run_op(16'h0001, 8'sd60, 1'b0, 1'b0, obs, lat, to, idle);
    n_checks++;
    if (to || obs !== expv || lat !== xlat) begin
      n_fail++;
      $display("FAIL reset_recover: got %h lat %0d required %h lat %0d", obs, lat, expv, xlat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.mant_i = '0;
    bus.exp_i = '0;
    bus.sign_i = 1'b0;
    bus.out_ready_i = 1'b0;
    test_reset();
    test_directed();
    test_random(150, 1'b0, "rand");
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
